fb_write_ctrl: RTL and testbench
================================

// Module: fb_write_ctrl
// PURPOSE
//  Write-side consumer of the per-pixel reduce stream. Takes resolved pixel writes (addr/hit/bri/valid)
//  and the end-of-frame swap flag, and writes them into the back bank of a double-buffered framebuffer.
//  Flips front/back banks on the next display vblank, stalling the renderer until the flip completes.
//  Sits between the reduce stage and the dual-bank framebuffer RAM; scan-out reads the bank given by front_sel.
// PARAMETERS
//  ADDR_W   20      pixel address width within one bank
//  PIX_W    8       brightness width
//  NUM_PIX  307200  pixels per bank; highest valid address = NUM_PIX-1
//  BG_BRI   8'h00   brightness written for non-hit pixels and by the clear pass
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  fb_addr      in   ADDR_W    pixel address of the write
//  hit          in   1         1 = triangle covered the pixel; 0 = background
//  bri          in   PIX_W     pixel brightness; used only when hit=1
//  valid        in   1         write strobe; one pixel per cycle
//  swap         in   1         qualifies valid: the current write is the frame's last pixel
//  vblank       in   1         display vertical-blank level from scan-out timing
//  mem_we       out  1         framebuffer write enable
//  mem_addr     out  ADDR_W+1  {bank, addr}; bank = ~front_sel
//  mem_wdata    out  PIX_W     write data
//  front_sel    out  1         bank currently displayed
//  render_stall out  1         upstream must hold off; no valid may be issued while it is 1
//  overrun      out  1         sticky; valid was seen while render_stall=1
//  frame_cnt    out  16        number of completed flips; wraps from 0xFFFF to 0
// BEHAVIOUR
//  Reset values: mem_we=0, mem_addr=0, mem_wdata=0, front_sel=0, render_stall=0, overrun=0, frame_cnt=0.
//    FSM state = RUN.
//  Write path: every mem_* output is registered; latency is 1 cycle.
//    In RUN, valid=1: mem_we=1, mem_addr={~front_sel, fb_addr}, mem_wdata = hit ? bri : BG_BRI.
//  FSM states: RUN, WAIT_VB, CLEAR (CLEAR exists only with FB_CLEAR_EN).
//  RUN -> WAIT_VB: on a cycle with valid=1 and swap=1. That write itself is performed.
//    render_stall goes to 1 on the next cycle.
//  WAIT_VB: render_stall=1 and mem_we=0. On the first cycle with vblank=1:
//    - front_sel toggles
//    - frame_cnt increments
//    - next state is RUN, or CLEAR with FB_CLEAR_EN.
//    If vblank is already 1 on entry, the flip happens on that first WAIT_VB cycle.
//  valid while render_stall=1: the write is dropped, overrun is set, and the state is unchanged.
//    overrun clears only on reset. swap without valid is ignored.
//  fb_addr >= NUM_PIX: the write is dropped and overrun is set.
//  Reset asserted mid-frame or mid-clear: the block returns immediately to the reset values.
//    front_sel returns to 0. Partially written bank contents are not restored.
// CONFIGURATION
//  FB_CLEAR_EN defined:
//    - After each flip, the FSM enters CLEAR with render_stall=1.
//    - CLEAR writes BG_BRI to back-bank addresses 0..NUM_PIX-1, one per cycle, ascending.
//    - It then returns to RUN; render_stall drops on the cycle after the write to address NUM_PIX-1.
//    - Flip to RUN takes exactly NUM_PIX+1 cycles.
//  FB_CLEAR_EN undefined:
//    - There is no CLEAR state; the FSM returns to RUN directly after the flip.
//    - The renderer is responsible for writing every pixel, with BG_BRI used for non-hit pixels.
// STRUCTURE
//  Shared package fb_pkg holds:
//    - fb_state_t enum {RUN, WAIT_VB, CLEAR}
//    - FB_ADDR_W, FB_PIX_W and FB_NUM_PIX constants, shared with the reduce stage and scan-out.
//  Sub-module fb_clear_gen (FB_CLEAR_EN only):
//    - Ports: start, busy, done, addr.
//    - Contains a 0..NUM_PIX-1 counter; done pulses on the cycle that issues the last address.
// TESTING
//  1 Reset, then valid with hit=1, bri=0x5A, addr=0x00010 -> next cycle mem_we=1, mem_addr=0x100010, mem_wdata=0x5A.
//  2 valid with hit=0, bri=0xFF -> mem_wdata=BG_BRI (0x00).
//  3 valid+swap with vblank=0 for 10 cycles, then vblank=1 -> render_stall=1 over the 10 cycles; flip on the vblank cycle:
//    front_sel=1, frame_cnt=1, render_stall=0 next cycle (FB_CLEAR_EN undefined).
//  4 valid during render_stall -> mem_we stays 0 and overrun=1, held until rst_n=0.
//  5 FB_CLEAR_EN with NUM_PIX=16: after the flip, exactly 16 writes to addrs 0..15 in bank ~front_sel with data 0x00;
//    stall ends 17 cycles after the flip.
//  6 rst_n=0 asynchronously in WAIT_VB, with front_sel=1 -> all outputs at reset values immediately; RUN after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and FSM state type. These are used by the reduce stage,
// the write controller and scan-out. The optional clear pass is enabled with FB_CLEAR_EN.
package fb_pkg;

    localparam int FB_ADDR_W  = 20;
    localparam int FB_PIX_W   = 8;
    localparam int FB_NUM_PIX = 307200;
    localparam logic [FB_PIX_W-1:0] FB_BG_BRI = 8'h00;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_VB = 2'd1,
        CLEAR   = 2'd2
    } fb_state_t;

    function automatic logic fb_addr_in_range(input logic [31:0] addr, input logic [31:0] num_pix);
        return addr < num_pix;
    endfunction

endpackage

// File: rtl/fb_clear_gen.sv
// Address sequencer for the back-bank clear pass: it walks 0..NUM_PIX-1, one address per cycle.
// It is instantiated by fb_write_ctrl only when FB_CLEAR_EN is defined.
module fb_clear_gen #(
    parameter int ADDR_W  = 20,
    parameter int NUM_PIX = 307200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    assign busy_o = busy_q;
    assign addr_o = cnt_q;
    assign done_o = busy_q && (cnt_q == ADDR_W'(NUM_PIX - 1));

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (done_o) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Writes resolved pixels into the back bank of a double-buffered framebuffer and flips banks on vblank.
// The optional post-flip clear of the new back bank is enabled with FB_CLEAR_EN.
import fb_pkg::*;

module fb_write_ctrl #(
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int PIX_W   = FB_PIX_W,
    parameter int NUM_PIX = FB_NUM_PIX,
    parameter logic [PIX_W-1:0] BG_BRI = FB_BG_BRI
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fb_addr_i,
    input  logic              hit_i,
    input  logic [PIX_W-1:0]  bri_i,
    input  logic              valid_i,
    input  logic              swap_i,
    input  logic              vblank_i,
    output logic              mem_we_o,
    output logic [ADDR_W:0]   mem_addr_o,
    output logic [PIX_W-1:0]  mem_wdata_o,
    output logic              front_sel_o,
    output logic              render_stall_o,
    output logic              overrun_o,
    output logic [15:0]       frame_cnt_o
);

    fb_state_t         state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              front_sel_q, front_sel_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              addr_ok;
    logic              flip;

    assign addr_ok = fb_addr_in_range(32'(fb_addr_i), 32'(NUM_PIX));
    assign flip    = (state_q == WAIT_VB) && vblank_i;

`ifdef FB_CLEAR_EN
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;

    fb_clear_gen #(
        .ADDR_W  (ADDR_W),
        .NUM_PIX (NUM_PIX)
    ) u_clear_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (flip),
        .busy_o  (clr_busy),
        .done_o  (clr_done),
        .addr_o  (clr_addr)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (valid_i && swap_i) begin
                    state_d = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank_i) begin
`ifdef FB_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                if (clr_done) begin
                    state_d = RUN;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    // The address and data registers hold their last value while no write is issued.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        front_sel_d = front_sel_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (valid_i && ((state_q != RUN) || !addr_ok)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (valid_i && addr_ok) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {~front_sel_q, fb_addr_i};
                    mem_wdata_d = hit_i ? bri_i : BG_BRI;
                end
            end
            WAIT_VB: begin
                if (flip) begin
                    front_sel_d = ~front_sel_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                mem_we_d    = clr_busy;
                mem_addr_d  = {~front_sel_q, clr_addr};
                mem_wdata_d = BG_BRI;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            front_sel_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            front_sel_q <= front_sel_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign front_sel_o    = front_sel_q;
    assign overrun_o      = overrun_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign render_stall_o = (state_q != RUN);

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl. It covers writes, bank flips, overrun, address bounds and async reset.
// When FB_CLEAR_EN is defined, the DUT is built with a 16-pixel bank and each clear pass is checked.
module tb_fb_write_ctrl;
    import fb_pkg::*;

`ifdef FB_CLEAR_EN
    localparam int TB_NUM_PIX = 16;
`else
    localparam int TB_NUM_PIX = FB_NUM_PIX;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] fb_addr;
    logic        hit;
    logic [7:0]  bri;
    logic        valid;
    logic        swap;
    logic        vblank;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        front_sel;
    logic        render_stall;
    logic        overrun;
    logic [15:0] frame_cnt;

    int passCount  = 0;
    int totalCount = 0;

    fb_write_ctrl #(
        .NUM_PIX (TB_NUM_PIX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fb_addr_i      (fb_addr),
        .hit_i          (hit),
        .bri_i          (bri),
        .valid_i        (valid),
        .swap_i         (swap),
        .vblank_i       (vblank),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .front_sel_o    (front_sel),
        .render_stall_o (render_stall),
        .overrun_o      (overrun),
        .frame_cnt_o    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic h,
                                 input logic [7:0] b, input logic [19:0] a);
        valid   = v;
        swap    = s;
        hit     = h;
        bri     = b;
        fb_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_we"},      32'(mem_we), 32'd0);
        checkOutput({tag, "_addr"},    32'(mem_addr), 32'd0);
        checkOutput({tag, "_wdata"},   32'(mem_wdata), 32'd0);
        checkOutput({tag, "_front"},   32'(front_sel), 32'd0);
        checkOutput({tag, "_stall"},   32'(render_stall), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_frame"},   32'(frame_cnt), 32'd0);
    endtask

    // Expected front/frame are the values after the flip.
    // In clear mode, a full back-bank sweep is also expected.
    task automatic flipCheck(input logic expFront, input logic [15:0] expFrame);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        checkOutput("flip_front", 32'(front_sel), 32'(expFront));
        checkOutput("flip_frame", 32'(frame_cnt), 32'(expFrame));
        checkOutput("flip_we",    32'(mem_we), 32'd0);
`ifdef FB_CLEAR_EN
        checkOutput("clr_stall_start", 32'(render_stall), 32'd1);
        for (int i = 0; i < TB_NUM_PIX; i++) begin
            tick();
            checkOutput("clr_we",    32'(mem_we), 32'd1);
            checkOutput("clr_addr",  32'(mem_addr), {11'd0, ~expFront, 20'(i)});
            checkOutput("clr_wdata", 32'(mem_wdata), 32'd0);
            checkOutput("clr_stall", 32'(render_stall), (i == TB_NUM_PIX - 1) ? 32'd0 : 32'd1);
        end
        tick();
        checkOutput("clr_end_we", 32'(mem_we), 32'd0);
`else
        checkOutput("flip_stall", 32'(render_stall), 32'd0);
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        vblank = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        #12;
        checkResetValues("reset");
        rst_n = 1'b1;

        // Write into bank 1 while bank 0 is displayed.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h5A, 20'h00010);
        tick();
        checkOutput("hit_we",    32'(mem_we), 32'd1);
        checkOutput("hit_addr",  32'(mem_addr), 32'h100010);
        checkOutput("hit_wdata", 32'(mem_wdata), 32'h5A);
        checkOutput("hit_stall", 32'(render_stall), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 20'h00020);
        tick();
        checkOutput("bg_we",    32'(mem_we), 32'd1);
        checkOutput("bg_addr",  32'(mem_addr), 32'h100020);
        checkOutput("bg_wdata", 32'(mem_wdata), 32'h00);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h12, 20'h00030);
        tick();
        checkOutput("noval_swap_we",    32'(mem_we), 32'd0);
        checkOutput("noval_swap_stall", 32'(render_stall), 32'd0);
        checkOutput("noval_addr_hold",  32'(mem_addr), 32'h100020);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 20'(TB_NUM_PIX - 1));
        tick();
        checkOutput("last_pix_we",    32'(mem_we), 32'd1);
        checkOutput("last_pix_addr",  32'(mem_addr), 32'h100000 + 32'(TB_NUM_PIX - 1));
        checkOutput("last_pix_wdata", 32'(mem_wdata), 32'h77);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h78, 20'(TB_NUM_PIX));
        tick();
        checkOutput("oob_we",      32'(mem_we), 32'd0);
        checkOutput("oob_overrun", 32'(overrun), 32'd1);
        checkOutput("oob_stall",   32'(render_stall), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_clears_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        // Frame end with vblank low for 10 cycles, then the flip.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h11, 20'h00030);
        tick();
        checkOutput("swap_we",    32'(mem_we), 32'd1);
        checkOutput("swap_addr",  32'(mem_addr), 32'h100030);
        checkOutput("swap_wdata", 32'(mem_wdata), 32'h11);
        checkOutput("swap_stall", 32'(render_stall), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("wait_stall", 32'(render_stall), 32'd1);
            checkOutput("wait_we",    32'(mem_we), 32'd0);
            checkOutput("wait_front", 32'(front_sel), 32'd0);
        end
        flipCheck(1'b1, 16'd1);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h33, 20'h00010);
        tick();
        checkOutput("bank0_addr",  32'(mem_addr), 32'h000010);
        checkOutput("bank0_wdata", 32'(mem_wdata), 32'h33);

        // vblank already high when WAIT_VB is entered.
        vblank = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h44, 20'h00040);
        tick();
        checkOutput("vbhi_addr",  32'(mem_addr), 32'h000040);
        checkOutput("vbhi_stall", 32'(render_stall), 32'd1);
        checkOutput("vbhi_front", 32'(front_sel), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        flipCheck(1'b0, 16'd2);

        // A write issued during the stall is dropped and flagged.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 20'h00050);
        tick();
        checkOutput("ovr_swap_addr", 32'(mem_addr), 32'h100050);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h99, 20'h00060);
        tick();
        checkOutput("ovr_we",      32'(mem_we), 32'd0);
        checkOutput("ovr_overrun", 32'(overrun), 32'd1);
        checkOutput("ovr_stall",   32'(render_stall), 32'd1);
        checkOutput("ovr_front",   32'(front_sel), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        flipCheck(1'b1, 16'd3);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset while waiting for vblank with bank 1 displayed.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h22, 20'h00070);
        tick();
        checkOutput("pre_rst_addr", 32'(mem_addr), 32'h000070);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        tick();
        checkOutput("pre_rst_stall", 32'(render_stall), 32'd1);
        checkOutput("pre_rst_front", 32'(front_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hAB, 20'h00005);
        tick();
        checkOutput("post_rst_we",    32'(mem_we), 32'd1);
        checkOutput("post_rst_addr",  32'(mem_addr), 32'h100005);
        checkOutput("post_rst_wdata", 32'(mem_wdata), 32'hAB);
        checkOutput("post_rst_stall", 32'(render_stall), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
